// File: rtl/seq_pkg.sv
// Shared definitions for the hit logger slice.
//   TS_W_DEF  : default timestamp width
//   CNT_W_DEF : default width of the hit and drop counters
//   DEPTH_DEF : default FIFO depth
//   level_w() : width needed to hold an occupancy of 0..depth
package seq_pkg;

  localparam int TS_W_DEF  = 16;
  localparam int CNT_W_DEF = 16;
  localparam int DEPTH_DEF = 8;

  // An occupancy of exactly DEPTH needs one bit more than the address.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/hit_fifo.sv
// Synchronous FIFO with registered full/empty flags.
//   clk, reset (async, active-high), clr (sync clear)
//   push/din  : write request and data
//   pop       : read request; ignored while empty
//   dout      : head entry, read straight from storage
//   full/empty/level : registered occupancy status
// A push while full is accepted only when a pop happens in the same cycle.
module hit_fifo
  import seq_pkg::*;
#(
  parameter int WIDTH = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          din,
  output logic [WIDTH-1:0]          dout,
  output logic                      full,
  output logic                      empty,
  output logic [level_w(DEPTH)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [LW-1:0]    level_nxt;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    level_nxt = level;
    if (do_push && !do_pop) level_nxt = level + LW'(1);
    else if (do_pop && !do_push) level_nxt = level - LW'(1);
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
      full  <= (level_nxt == LW'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

  // Storage is cleared so the head reads 0 straight after reset or clr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/seq_hit_logger.sv
// Timestamps detector hits and queues them for a valid/ready consumer.
//   clk, reset (async, active-high), clr (sync clear of everything)
//   hit        : one-cycle detector pulse
//   out_valid/out_ready/out_ts : head of the timestamp queue
//   hit_count  : all hits seen, saturating
//   drop_count : hits lost to a full queue, saturating
//   overflow   : sticky, set on the first drop
//   fifo_level : current queue occupancy
// Handshake: an entry leaves the queue at a clock edge where out_valid and
// out_ready are both high; out_ts is held stable while out_valid is high
// and out_ready is low.
module seq_hit_logger
  import seq_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr,
  input  logic                      hit,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [TS_W-1:0]           out_ts,
  output logic [CNT_W-1:0]          hit_count,
  output logic [CNT_W-1:0]          drop_count,
  output logic                      overflow,
  output logic [level_w(DEPTH)-1:0] fifo_level
);

  logic [TS_W-1:0] ts;
  logic            full;
  logic            empty;
  logic            pop;
  logic            drop;

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so only a full queue with no
  // pop loses the hit.
  assign drop      = hit && full && !pop;

  hit_fifo #(
    .WIDTH (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .push  (hit),
    .pop   (out_ready),
    .din   (ts),
    .dout  (out_ts),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts         <= '0;
      hit_count  <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (clr) begin
      ts         <= '0;
      hit_count  <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      ts <= ts + TS_W'(1);
      if (hit && (hit_count != '1)) hit_count <= hit_count + CNT_W'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_hit_logger.sv
module tb_seq_hit_logger;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        clr;
  logic        hit;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_ts;
  logic [15:0] hit_count;
  logic [15:0] drop_count;
  logic        overflow;
  logic [3:0]  fifo_level;

  // Narrow-timestamp instance for the wrap check.
  logic        hit4;
  logic        ready4;
  logic        clr4;
  logic        valid4;
  logic [3:0]  ts4;
  logic [7:0]  hc4;
  logic [7:0]  dc4;
  logic        ovf4;
  logic [1:0]  lvl4;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state.
  logic [15:0] q[$];
  int          m_ts;
  int          m_hc;
  int          m_dc;
  bit          m_ovf;

  seq_hit_logger #(.TS_W(16), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .clr(clr), .hit(hit),
    .out_valid(out_valid), .out_ready(out_ready), .out_ts(out_ts),
    .hit_count(hit_count), .drop_count(drop_count),
    .overflow(overflow), .fifo_level(fifo_level)
  );

  seq_hit_logger #(.TS_W(4), .DEPTH(2), .CNT_W(8)) u_small (
    .clk(clk), .reset(reset), .clr(clr4), .hit(hit4),
    .out_valid(valid4), .out_ready(ready4), .out_ts(ts4),
    .hit_count(hc4), .drop_count(dc4),
    .overflow(ovf4), .fifo_level(lvl4)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ts  = 0;
    m_hc  = 0;
    m_dc  = 0;
    m_ovf = 0;
  endtask

  // Next state from the behavioural rules for one clock edge.
  task automatic model_step(input bit h, input bit r, input bit c);
    bit was_full;
    bit popped;
    if (c) begin
      model_reset();
      return;
    end
    was_full = (q.size() == DEPTH);
    popped   = (q.size() != 0) && r;
    if (popped) void'(q.pop_front());
    if (h) begin
      if (m_hc < 65535) m_hc++;
      if (!was_full || popped) q.push_back(16'(m_ts));
      else begin
        if (m_dc < 65535) m_dc++;
        m_ovf = 1;
      end
    end
    m_ts = (m_ts + 1) % 65536;
  endtask

  task automatic compare_all();
    chk("valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("out_ts", 32'(out_ts), 32'(q[0]));
    chk("level", 32'(fifo_level), 32'(q.size()));
    chk("hit_count", 32'(hit_count), 32'(m_hc));
    chk("drop_count", 32'(drop_count), 32'(m_dc));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // Driver: one cycle, entered and left just after a falling edge.
  task automatic tick(input bit h, input bit r, input bit c);
    compare_all();
    hit       = h;
    out_ready = r;
    clr       = c;
    model_step(h, r, c);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] saved;
    int rp;
    reset = 1'b1; clr = 0; hit = 0; out_ready = 0;
    hit4 = 0; ready4 = 0; clr4 = 0;
    model_reset();
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ts", 32'(out_ts), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_hc", 32'(hit_count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Directed: single hit, ordered drain, narrow timestamp wrap.
    for (int c = 0; c < 21; c++) begin
      case (c)
        6:  begin chk("t1_valid", 32'(out_valid), 1); chk("t1_ts", 32'(out_ts), 5); end
        7:  begin chk("t1_valid_lo", 32'(out_valid), 0); chk("t1_hc", 32'(hit_count), 1); end
        13: begin chk("t2_ts0", 32'(out_ts), 10); chk("t2_lvl3", 32'(fifo_level), 3); end
        14: begin chk("t2_ts1", 32'(out_ts), 11); chk("t2_lvl2", 32'(fifo_level), 2); end
        15: begin chk("t2_ts2", 32'(out_ts), 12); chk("t2_lvl1", 32'(fifo_level), 1); end
        16: chk("t2_lvl0", 32'(fifo_level), 0);
        18: begin chk("t5_valid", 32'(valid4), 1); chk("t5_ts15", 32'(ts4), 15); end
        19: chk("t5_ts1", 32'(ts4), 1);
        20: chk("t5_empty", 32'(valid4), 0);
        default: ;
      endcase
      hit4   = (c == 15) || (c == 17);
      ready4 = (c >= 18);
      tick((c == 5) || (c == 10) || (c == 11) || (c == 12), (c == 6) || (c >= 13), 1'b0);
    end
    hit4 = 0; ready4 = 0;

    // Overflow, sticky flag, clear.
    tick(0, 0, 1);
    for (int i = 0; i < 10; i++) tick(1, 0, 0);
    chk("t3_lvl", 32'(fifo_level), 8);
    chk("t3_drop", 32'(drop_count), 2);
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_hc", 32'(hit_count), 10);
    for (int i = 0; i < 8; i++) tick(0, 1, 0);
    chk("t3_drained", 32'(fifo_level), 0);
    chk("t3_ovf_sticky", 32'(overflow), 1);
    tick(0, 0, 1);
    chk("t3_clr_hc", 32'(hit_count), 0);
    chk("t3_clr_dc", 32'(drop_count), 0);
    chk("t3_clr_ovf", 32'(overflow), 0);
    chk("t3_clr_valid", 32'(out_valid), 0);

    // Full with simultaneous pop and hit.
    for (int i = 0; i < 8; i++) tick(1, 0, 0);
    saved = 16'(m_ts);
    tick(1, 1, 0);
    chk("t4_lvl", 32'(fifo_level), 8);
    chk("t4_drop", 32'(drop_count), 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("t4_last", 32'(out_ts), 32'(saved));
      tick(0, 1, 0);
    end

    // Async reset with 5 entries queued.
    for (int i = 0; i < 5; i++) tick(1, 0, 0);
    chk("t6_pre_lvl", 32'(fifo_level), 5);
    hit = 0;
    #2 reset = 1'b1;
    #1;
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_lvl", 32'(fifo_level), 0);
    chk("t6_hc", 32'(hit_count), 0);
    chk("t6_dc", 32'(drop_count), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) begin chk("t6_after_valid", 32'(out_valid), 1); chk("t6_after_ts", 32'(out_ts), 3); end
      tick(c == 3, 0, 0);
    end

    // Randomized traffic against the model.
    rp = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) rp = $urandom_range(0, 2) * 40 + 10;
      tick($urandom_range(0, 99) < 50, $urandom_range(0, 99) < rp, $urandom_range(0, 199) == 0);
    end
    compare_all();

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
